// File: rtl/eq_band_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : eq_band_scheduler
// Brief    : Shares one band-filter engine across NUM_BANDS equalizer bands,
//            gain-weights and accumulates the results, emits one saturated
//            output sample per input sample.
// Revision : 1.0 - initial release
// ============================================================================
module eq_band_scheduler #(
  parameter int NUM_BANDS = 10,
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              gain_wr_en,
  input  logic [3:0]        gain_wr_addr,
  input  logic [GAIN_W-1:0] gain_wr_data,
  output logic              eng_start,
  output logic [3:0]        eng_band,
  output logic [DATA_W-1:0] eng_sample,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_out_valid,
  output logic              drop_flag,
  output logic              sat_flag
);

  localparam int c_PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [3:0] c_LAST_BAND = 4'(NUM_BANDS - 1);
  localparam logic [GAIN_W-1:0] c_UNITY = GAIN_W'(1) << GAIN_FRAC;
  localparam logic signed [ACC_W-1:0] c_OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_OUT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [GAIN_W-1:0]        r_pend_gain [NUM_BANDS];
  logic [GAIN_W-1:0]        r_act_gain  [NUM_BANDS];
  logic [DATA_W-1:0]        r_sample;
  logic [3:0]               r_band;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_audio_out;
  logic                     r_out_valid;
  logic                     r_drop;
  logic                     r_sat;

  logic                     w_accept;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_sat_out;
  logic                     w_clip;

  assign w_accept = (r_state == S_IDLE) && sample_valid;

  // Pending gains take writes any time; active gains snapshot them only when
  // a sample is accepted, so a band's gain never changes mid-sample.
  generate
    for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band_gain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend_gain[gi] <= c_UNITY;
          r_act_gain[gi]  <= c_UNITY;
        end else begin
          if (gain_wr_en && (gain_wr_addr == 4'(gi))) begin
            r_pend_gain[gi] <= gain_wr_data;
          end
          if (w_accept) begin
            r_act_gain[gi] <= r_pend_gain[gi];
          end
        end
      end
    end
  endgenerate

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_prod     = $signed(eng_result) * $signed({1'b0, r_act_gain[r_band]});
  assign w_prod_ext = {{(ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
  assign w_shift    = r_acc >>> GAIN_FRAC;

  always_comb begin
    w_sat_out = w_shift[DATA_W-1:0];
    w_clip    = 1'b0;
    if (w_shift > c_OUT_MAX) begin
      w_sat_out = c_OUT_MAX[DATA_W-1:0];
      w_clip    = 1'b1;
    end else if (w_shift < c_OUT_MIN) begin
      w_sat_out = c_OUT_MIN[DATA_W-1:0];
      w_clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    sample_ready = 1'b0;
    eng_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          w_next_state = (r_band == c_LAST_BAND) ? S_OUTPUT : S_ISSUE;
        end
      end
      S_OUTPUT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample    <= '0;
      r_band      <= '0;
      r_acc       <= '0;
      r_audio_out <= '0;
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_OUTPUT);
      if (sample_valid && (r_state != S_IDLE)) begin
        r_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            r_sample <= sample_in;
            r_acc    <= '0;
            r_band   <= '0;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            r_acc <= r_acc + w_prod_ext;
            if (r_band != c_LAST_BAND) begin
              r_band <= r_band + 4'd1;
            end
          end
        end
        S_OUTPUT: begin
          r_audio_out <= w_sat_out;
          if (w_clip) begin
            r_sat <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign eng_band        = r_band;
  assign eng_sample      = r_sample;
  assign audio_out       = r_audio_out;
  assign audio_out_valid = r_out_valid;
  assign drop_flag       = r_drop;
  assign sat_flag        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_eq_band_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq_band_scheduler
// Brief    : Scoreboard bench for eq_band_scheduler with a stub band engine
//            (result = sample, configurable latency).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eq_band_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        gain_wr_en = 1'b0;
  logic [3:0]  gain_wr_addr = '0;
  logic [7:0]  gain_wr_data = '0;
  logic        eng_start;
  logic [3:0]  eng_band;
  logic [23:0] eng_sample;
  logic        eng_done;
  logic [23:0] eng_result;
  logic [23:0] audio_out;
  logic        audio_out_valid;
  logic        drop_flag;
  logic        sat_flag;

  eq_band_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .gain_wr_en      (gain_wr_en),
    .gain_wr_addr    (gain_wr_addr),
    .gain_wr_data    (gain_wr_data),
    .eng_start       (eng_start),
    .eng_band        (eng_band),
    .eng_sample      (eng_sample),
    .eng_done        (eng_done),
    .eng_result      (eng_result),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .drop_flag       (drop_flag),
    .sat_flag        (sat_flag)
  );

  always #10 clk = ~clk;

  // Stub engine: done pulses lat cycles after start, result echoes the sample.
  int         lat = 1;
  logic [7:0] r_sh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= '0;
    else        r_sh <= {r_sh[6:0], eng_start};
  end
  assign eng_done   = r_sh[3'(lat - 1)];
  assign eng_result = eng_sample;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  int q_val[$];
  int q_cyc[$];
  int ev, ec;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && audio_out_valid) begin
      n_out++;
      if (q_val.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0d expected none", $signed(audio_out));
      end else begin
        ev = q_val.pop_front();
        ec = q_cyc.pop_front();
        chk("audio_out", $signed(audio_out), ev);
        chk("latency", cyc, ec);
      end
    end
  end

  task automatic send(input int v, input int exp_v, input int exp_lat, input bit push);
    int k = 0;
    @(negedge clk);
    while (!sample_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!sample_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    sample_in    = v[23:0];
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      q_val.push_back(exp_v);
      q_cyc.push_back(cyc + exp_lat);
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_out();
    int k = 0;
    while (q_val.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q_val.size(), 0);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    gain_wr_en   = 1'b1;
    gain_wr_addr = a[3:0];
    gain_wr_data = d[7:0];
    @(negedge clk);
    gain_wr_en   = 1'b0;
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < 10; i++) wr(i, d);
  endtask

  initial begin
    int base;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_valid", audio_out_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_band", eng_band, 0);
    chk("rst_eng_sample", eng_sample, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_drop", drop_flag, 0);
    chk("rst_sat", sat_flag, 0);
    rst_n = 1'b1;

    send(1000, 10000, 21, 1'b1);
    wait_out();

    set_all(17);
    send(160, 1700, 21, 1'b1);
    wait_out();
    send(-160, -1700, 21, 1'b1);
    wait_out();
    chk("sat_flag_clear", sat_flag, 0);

    set_all(255);
    send(32'h7FFFFF, 8388607, 21, 1'b1);
    wait_out();
    chk("sat_flag_set", sat_flag, 1);
    send(32'h800000, -8388608, 21, 1'b1);
    wait_out();

    set_all(16);
    send(1000, 10000, 21, 1'b1);
    repeat (4) @(negedge clk);
    wr(3, 0);
    wait_out();
    send(1000, 9000, 21, 1'b1);
    wait_out();
    wr(12, 0);
    send(1000, 9000, 21, 1'b1);
    wait_out();

    chk("drop_clear", drop_flag, 0);
    base = n_out;
    send(1000, 9000, 21, 1'b1);
    repeat (3) @(negedge clk);
    sample_in    = 24'd5;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_out();
    repeat (30) @(negedge clk);
    chk("drop_set", drop_flag, 1);
    chk("one_pulse", n_out - base, 1);

    lat = 3;
    send(1000, 9000, 41, 1'b1);
    wait_out();
    lat = 1;

    send(1000, 0, 0, 1'b0);
    k = 0;
    @(negedge clk);
    while (!(eng_band == 4'd5 && !eng_start && !sample_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_band5", eng_band, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", sample_ready, 1);
    chk("post_rst_audio", audio_out, 0);
    chk("post_rst_drop", drop_flag, 0);
    chk("post_rst_sat", sat_flag, 0);
    repeat (30) @(negedge clk);
    send(1000, 10000, 21, 1'b1);
    wait_out();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
